// File: rtl/id_ex_stage_reg_pkg.sv
// Shared MIPS32 definitions for the ID/EX stage: control-bit bundle, ALUOp codes,
// the zero register number and the operand-field hazard match.
package id_ex_stage_reg_pkg;

  localparam int DATA_W_DEFAULT = 32;
  localparam int CTRL_W         = 8;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'(8'd0);

  // A write to $zero never creates a dependency.
  function automatic logic fields_match(input logic [4:0] ex_rt,
                                        input logic [4:0] id_rs,
                                        input logic [4:0] id_rt);
    return (ex_rt != REG_ZERO) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  endfunction

endpackage

// File: rtl/id_ex_stage_reg_hazard_detect.sv
// Load-use hazard detection: flags a load in EX whose destination is a source
// of the instruction in ID, and derives the PC / IF-ID write enables.
module hazard_detect
  import id_ex_stage_reg_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic       ex_valid,
  input  logic [4:0] ex_rt_field,
  input  logic [4:0] id_rs_field,
  input  logic [4:0] id_rt_field,
  input  logic       hold,
  output logic       hz,
  output logic       pc_write,
  output logic       if_id_write
);

  // Hazard and stall enables are purely combinational.
  always_comb begin
    hz          = ex_mem_read & ex_valid & fields_match(ex_rt_field, id_rs_field, id_rt_field);
    pc_write    = ~(hz | hold);
    if_id_write = ~(hz | hold);
  end

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating
// count of hazard bubbles.
module id_ex_stage_reg
  import id_ex_stage_reg_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              hold,
  input  logic              ID_RegWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [1:0]        ID_ALUOp,
  input  logic [DATA_W-1:0] ID_ReadData1,
  input  logic [DATA_W-1:0] ID_ReadData2,
  input  logic [DATA_W-1:0] ID_SignImm,
  input  logic [DATA_W-1:0] ID_PC4,
  input  logic [4:0]        IF_ID_RS_field,
  input  logic [4:0]        IF_ID_RT_field,
  input  logic [4:0]        IF_ID_RD_field,
  output logic              ID_EX_RegWrite,
  output logic              ID_EX_MemtoReg,
  output logic              ID_EX_MemRead,
  output logic              ID_EX_MemWrite,
  output logic              ID_EX_ALUSrc,
  output logic              ID_EX_RegDst,
  output logic [1:0]        ID_EX_ALUOp,
  output logic [DATA_W-1:0] ID_EX_ReadData1,
  output logic [DATA_W-1:0] ID_EX_ReadData2,
  output logic [DATA_W-1:0] ID_EX_SignImm,
  output logic [DATA_W-1:0] ID_EX_PC4,
  output logic [4:0]        ID_EX_RS_field,
  output logic [4:0]        ID_EX_RT_field,
  output logic [4:0]        ID_EX_RD_field,
  output logic              ID_EX_Valid,
  output logic              PC_Write,
  output logic              IF_ID_Write,
  output logic [CNT_W-1:0]  Bubble_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  ctrl_t              ctrl_in_s, ctrl_r, ctrl_n_s;
  logic               valid_r, valid_n_s;
  logic [4:0]         rs_r, rt_r, rd_r, rs_n_s, rt_n_s, rd_n_s;
  logic [DATA_W-1:0]  rd1_r, rd2_r, imm_r, pc4_r;
  logic [DATA_W-1:0]  rd1_n_s, rd2_n_s, imm_n_s, pc4_n_s;
  logic [CNT_W-1:0]   cnt_r, cnt_n_s;
  logic               hz_s;

  assign ctrl_in_s = '{reg_write: ID_RegWrite, mem_to_reg: ID_MemtoReg, mem_read: ID_MemRead,
                       mem_write: ID_MemWrite, alu_src: ID_ALUSrc, reg_dst: ID_RegDst,
                       alu_op: ID_ALUOp};

  hazard_detect u_hazard (
    .ex_mem_read (ctrl_r.mem_read),
    .ex_valid    (valid_r),
    .ex_rt_field (rt_r),
    .id_rs_field (IF_ID_RS_field),
    .id_rt_field (IF_ID_RT_field),
    .hold        (hold),
    .hz          (hz_s),
    .pc_write    (PC_Write),
    .if_id_write (IF_ID_Write)
  );

  // Priority mux: hold freezes, flush and hazards insert a bubble, else capture.
  always_comb begin
    ctrl_n_s  = ctrl_r;
    valid_n_s = valid_r;
    rs_n_s    = rs_r;
    rt_n_s    = rt_r;
    rd_n_s    = rd_r;
    rd1_n_s   = rd1_r;
    rd2_n_s   = rd2_r;
    imm_n_s   = imm_r;
    pc4_n_s   = pc4_r;
    cnt_n_s   = cnt_r;
    if (hold) begin
      cnt_n_s = cnt_r;
    end else if (flush || hz_s) begin
      ctrl_n_s  = CTRL_BUBBLE;
      valid_n_s = 1'b0;
      rs_n_s    = REG_ZERO;
      rt_n_s    = REG_ZERO;
      rd_n_s    = REG_ZERO;
      rd1_n_s   = {DATA_W{1'b0}};
      rd2_n_s   = {DATA_W{1'b0}};
      imm_n_s   = {DATA_W{1'b0}};
      pc4_n_s   = {DATA_W{1'b0}};
      // Only hazard bubbles are counted; a coincident flush takes precedence.
      if (!flush && (cnt_r != CNT_MAX)) begin
        cnt_n_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt_n_s = cnt_r;
      end
    end else begin
      ctrl_n_s  = ctrl_in_s;
      valid_n_s = 1'b1;
      rs_n_s    = IF_ID_RS_field;
      rt_n_s    = IF_ID_RT_field;
      rd_n_s    = IF_ID_RD_field;
      rd1_n_s   = ID_ReadData1;
      rd2_n_s   = ID_ReadData2;
      imm_n_s   = ID_SignImm;
      pc4_n_s   = ID_PC4;
    end
  end

  // Stage register bank and bubble counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_r  <= CTRL_BUBBLE;
      valid_r <= 1'b0;
      rs_r    <= REG_ZERO;
      rt_r    <= REG_ZERO;
      rd_r    <= REG_ZERO;
      rd1_r   <= {DATA_W{1'b0}};
      rd2_r   <= {DATA_W{1'b0}};
      imm_r   <= {DATA_W{1'b0}};
      pc4_r   <= {DATA_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
    end else begin
      ctrl_r  <= ctrl_n_s;
      valid_r <= valid_n_s;
      rs_r    <= rs_n_s;
      rt_r    <= rt_n_s;
      rd_r    <= rd_n_s;
      rd1_r   <= rd1_n_s;
      rd2_r   <= rd2_n_s;
      imm_r   <= imm_n_s;
      pc4_r   <= pc4_n_s;
      cnt_r   <= cnt_n_s;
    end
  end

  assign ID_EX_RegWrite  = ctrl_r.reg_write;
  assign ID_EX_MemtoReg  = ctrl_r.mem_to_reg;
  assign ID_EX_MemRead   = ctrl_r.mem_read;
  assign ID_EX_MemWrite  = ctrl_r.mem_write;
  assign ID_EX_ALUSrc    = ctrl_r.alu_src;
  assign ID_EX_RegDst    = ctrl_r.reg_dst;
  assign ID_EX_ALUOp     = ctrl_r.alu_op;
  assign ID_EX_ReadData1 = rd1_r;
  assign ID_EX_ReadData2 = rd2_r;
  assign ID_EX_SignImm   = imm_r;
  assign ID_EX_PC4       = pc4_r;
  assign ID_EX_RS_field  = rs_r;
  assign ID_EX_RT_field  = rt_r;
  assign ID_EX_RD_field  = rd_r;
  assign ID_EX_Valid     = valid_r;
  assign Bubble_Count    = cnt_r;

endmodule
